// File: rtl/pipe_stage_skid_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake.
// With SKID=1 a second entry absorbs the beat that is in flight when the
// downstream stalls, so in_ready comes straight from a register. With SKID=0
// there is a single entry and in_ready looks at out_ready combinationally.
// Any flush bit empties the stage. Reset has priority over flush.
module pipe_stage_skid_reg #(
    parameter int                DATA_W  = 97,
    parameter int                FLUSH_N = 2,
    parameter int                SKID    = 1,
    parameter logic [DATA_W-1:0] BUBBLE  = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [FLUSH_N-1:0] flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy
);

    // The state encoding equals the number of entries held, so occupancy is
    // simply the state register.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_reg;
    logic [DATA_W-1:0] skid_next;

    logic in_fire;
    logic out_fire;
    logic flush_any;

    assign flush_any = |flush;
    assign out_valid = (state_reg != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign occupancy = state_reg;

    // main_reg is already BUBBLE whenever the stage is empty; the mux makes
    // the output safe even if that invariant were ever broken.
    assign out_data  = out_valid ? main_reg : BUBBLE;

    generate
        if (SKID != 0) begin : g_skid
            // Registered ready: only the state decides, never out_ready.
            assign in_ready = (state_reg != ST_SKID);
        end else begin : g_noskid
            // Single entry: a slot frees up in the same cycle it drains.
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Next-state and data selection; flush overrides every transition.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush_any) begin
            state_next = ST_EMPTY;
            main_next  = BUBBLE;
            skid_next  = BUBBLE;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_FULL;
                        main_next  = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire && (SKID != 0)) begin
                        // Downstream stalled: park the new beat behind main.
                        state_next = ST_SKID;
                        skid_next  = in_data;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                        main_next  = BUBBLE;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        // Skid entry moves up only after main has left: FIFO order.
                        state_next = ST_FULL;
                        main_next  = skid_reg;
                        skid_next  = BUBBLE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_next  = BUBBLE;
                    skid_next  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            main_reg  <= BUBBLE;
            skid_reg  <= BUBBLE;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a SKID=1 instance checked by a scoreboard
// plus directed checks, and a SKID=0 instance checked with directed vectors.
module tb_pipe_stage_skid_reg;

    localparam int W = 97;

    logic         clk = 1'b0;
    logic         a_rst = 1'b1;
    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [W-1:0] a_in_data = '0;
    logic [1:0]   a_flush = 2'b00;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_occ;

    logic         b_rst = 1'b1;
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [7:0]   b_in_data = '0;
    logic [1:0]   b_flush = 2'b00;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [7:0]   b_out_data;
    logic [1:0]   b_occ;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(W), .FLUSH_N(2), .SKID(1)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .occupancy(a_occ)
    );

    pipe_stage_skid_reg #(.DATA_W(8), .FLUSH_N(2), .SKID(0)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .occupancy(b_occ)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [W-1:0] d,
                         input logic [1:0] occ, input logic rdy);
        chk({tag, ".out_valid"}, W'(a_out_valid), W'(v));
        chk({tag, ".out_data"},  a_out_data, d);
        chk({tag, ".occupancy"}, W'(a_occ), W'(occ));
        chk({tag, ".in_ready"},  W'(a_in_ready), W'(rdy));
        $display("step %s: valid=%0b data=0x%0h occ=%0d in_ready=%0b",
                 tag, a_out_valid, a_out_data, a_occ, a_in_ready);
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] occ, input logic rdy);
        chk({tag, ".out_valid"}, W'(b_out_valid), W'(v));
        chk({tag, ".out_data"},  W'(b_out_data), W'(d));
        chk({tag, ".occupancy"}, W'(b_occ), W'(occ));
        chk({tag, ".in_ready"},  W'(b_in_ready), W'(rdy));
        $display("step %s: valid=%0b data=0x%0h occ=%0d in_ready=%0b",
                 tag, b_out_valid, b_out_data, b_occ, b_in_ready);
    endtask

    // Scoreboard monitor for dut_a, sampling mid-cycle where everything is settled.
    logic         p_stall_out = 1'b0;
    logic [W-1:0] p_out_data = '0;
    logic         p_stall_in = 1'b0;
    logic [W-1:0] p_in_data = '0;
    always @(negedge clk) begin
        if (p_stall_out) begin
            chk("hold.out_valid", W'(a_out_valid), W'(1'b1));
            chk("hold.out_data", a_out_data, p_out_data);
        end
        if (p_stall_in) begin
            chk("upstream.in_valid", W'(a_in_valid), W'(1'b1));
            chk("upstream.in_data", a_in_data, p_in_data);
        end
        if (!a_out_valid)
            chk("empty.out_data", a_out_data, '0);
        if (a_rst) begin
            exp_q.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb.unexpected_output", a_out_data, '1);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("sb.out_data", a_out_data, e);
                    $display("sb: out 0x%0h expected 0x%0h", a_out_data, e);
                end
            end
            if (|a_flush)
                exp_q.delete();
            else if (a_in_valid && a_in_ready)
                exp_q.push_back(a_in_data);
        end
        p_stall_out <= a_out_valid && !a_out_ready && !a_rst && !(|a_flush);
        p_out_data  <= a_out_data;
        p_stall_in  <= a_in_valid && !a_in_ready && !a_rst && !(|a_flush);
        p_in_data   <= a_in_data;
    end

    initial begin
        // Reset then idle
        a_rst = 1'b1; b_rst = 1'b1;
        cyc();
        a_rst = 1'b0; b_rst = 1'b0;
        chk_a("reset", 1'b0, '0, 2'd0, 1'b1);

        // Streaming 1..4 with out_ready high
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_data = W'(i);
            cyc();
            chk_a($sformatf("stream%0d", i), 1'b1, W'(i), 2'd1, 1'b1);
        end
        a_in_valid = 1'b0;
        cyc();
        chk_a("stream_drain", 1'b0, '0, 2'd0, 1'b1);

        // Back-pressure into the skid entry
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = W'(8'h11);
        cyc();
        chk_a("skidA", 1'b1, W'(8'h11), 2'd1, 1'b1);
        a_in_data = W'(8'h22);
        cyc();
        chk_a("skidB", 1'b1, W'(8'h11), 2'd2, 1'b0);
        a_in_valid = 1'b0;
        cyc();
        chk_a("skid_hold", 1'b1, W'(8'h11), 2'd2, 1'b0);
        a_out_ready = 1'b1;
        cyc();
        chk_a("skid_pop1", 1'b1, W'(8'h22), 2'd1, 1'b1);
        cyc();
        chk_a("skid_pop2", 1'b0, '0, 2'd0, 1'b1);

        // Flush from SKID with C offered
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = W'(8'hA1);
        cyc();
        a_in_data = W'(8'hB2);
        cyc();
        chk_a("flush_pre", 1'b1, W'(8'hA1), 2'd2, 1'b0);
        a_in_data = W'(8'hC3); a_flush = 2'b10;
        cyc();
        a_flush = 2'b00; a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk_a("flush_skid", 1'b0, '0, 2'd0, 1'b1);
        cyc();
        chk_a("flush_noC", 1'b0, '0, 2'd0, 1'b1);

        // Flush from FULL discards an accepted in_fire beat
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = W'(8'hD4);
        cyc();
        a_in_data = W'(8'hE5); a_flush = 2'b01;
        cyc();
        a_flush = 2'b00; a_in_valid = 1'b0;
        chk_a("flush_full", 1'b0, '0, 2'd0, 1'b1);

        // Simultaneous in/out in FULL
        a_in_valid = 1'b1; a_in_data = W'(4'h5);
        cyc();
        chk_a("sim_load", 1'b1, W'(4'h5), 2'd1, 1'b1);
        a_in_data = W'(4'h6); a_out_ready = 1'b1;
        cyc();
        chk_a("sim_swap", 1'b1, W'(4'h6), 2'd1, 1'b1);
        a_in_valid = 1'b0;
        cyc();
        chk_a("sim_drain", 1'b0, '0, 2'd0, 1'b1);

        // Reset mid-operation, then reset together with flush
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_data = W'(8'h31);
        cyc();
        a_in_data = W'(8'h32);
        cyc();
        chk_a("rst_pre", 1'b1, W'(8'h31), 2'd2, 1'b0);
        a_in_valid = 1'b0; a_rst = 1'b1;
        cyc();
        a_rst = 1'b0;
        chk_a("rst_mid", 1'b0, '0, 2'd0, 1'b1);
        a_in_valid = 1'b1; a_in_data = W'(8'h41);
        cyc();
        a_in_data = W'(8'h42);
        cyc();
        a_in_data = W'(8'h43); a_rst = 1'b1; a_flush = 2'b11;
        cyc();
        a_rst = 1'b0; a_flush = 2'b00; a_in_valid = 1'b0;
        chk_a("rst_flush", 1'b0, '0, 2'd0, 1'b1);
        chk("rst_flush.no_x", W'($isunknown({a_out_valid, a_out_data, a_occ, a_in_ready})), '0);
        a_out_ready = 1'b1;
        cyc();
        chk_a("rst_after", 1'b0, '0, 2'd0, 1'b1);

        // SKID=0 instance: combinational ready and replace-in-FULL
        chk_b("b_reset", 1'b0, 8'h00, 2'd0, 1'b1);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1; b_in_data = 8'h05;
        cyc();
        chk_b("b_load", 1'b1, 8'h05, 2'd1, 1'b0);
        b_in_data = 8'h06;
        cyc();
        chk_b("b_blocked", 1'b1, 8'h05, 2'd1, 1'b0);
        b_out_ready = 1'b1;
        #1;
        chk("b_comb_ready", W'(b_in_ready), W'(1'b1));
        cyc();
        chk_b("b_swap", 1'b1, 8'h06, 2'd1, 1'b1);
        b_in_valid = 1'b0;
        cyc();
        chk_b("b_drain", 1'b0, 8'h00, 2'd0, 1'b1);
        b_in_valid = 1'b1; b_in_data = 8'h07; b_out_ready = 1'b0;
        cyc();
        b_flush = 2'b10; b_in_valid = 1'b0;
        cyc();
        b_flush = 2'b00;
        chk_b("b_flush", 1'b0, 8'h00, 2'd0, 1'b1);

        cyc();
        chk("sb.queue_empty", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised inter-stage pipeline register for the pip_cpu pipeline: the generalised successor of the fixed IF/ID latch. Carries an arbitrary-width payload (e.g. inst+pc+bpu_jump = 97 bits) between any two stages with a valid/ready handshake, an optional 2-entry skid buffer that registers the upstream ready path, and an N-way flush vector. It replaces per-stage hand-written stall/flush registers.

Parameters:
DATA_W, 97, payload width in bits.
FLUSH_N, 2, number of independent flush sources (e.g. id_flush, ex_flush).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
BUBBLE, {DATA_W{1'b0}}, payload value loaded on reset/flush and presented while empty.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  upstream payload valid.
in_ready  output  1  block can accept; transfer when in_valid & in_ready ("in_fire").
in_data  input  DATA_W  upstream payload.
flush  input  FLUSH_N  flush requests; any bit set flushes the stage.
out_valid  output  1  downstream payload valid.
out_ready  input  1  downstream accepts; transfer when out_valid & out_ready ("out_fire").
out_data  output  DATA_W  payload to downstream; equals BUBBLE when out_valid=0.
occupancy  output  2  entries held: 0, 1, or 2 (2 only if SKID=1).

Behaviour:
- Reset (rst=1 at posedge): state EMPTY, main and skid data = BUBBLE; outputs out_valid=0, out_data=BUBBLE, occupancy=0, in_ready=1 (SKID=1) / 1 (SKID=0, since empty).
- Latency: payload accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle). No combinational in_data->out_data path.
- State machine (SKID=1): EMPTY, FULL (main only), SKID (main+skid).
  EMPTY: in_fire -> FULL, main<=in_data. Else stay.
  FULL: in_fire & out_fire -> FULL, main<=in_data. in_fire & !out_fire -> SKID, skid<=in_data. !in_fire & out_fire -> EMPTY, main<=BUBBLE. Else hold.
  SKID: in_ready=0. out_fire -> FULL, main<=skid, skid<=BUBBLE. Else hold.
- in_ready (SKID=1) is a pure function of registered state: 1 in EMPTY/FULL, 0 in SKID; never depends on out_ready combinationally.
- SKID=0: states EMPTY/FULL only; in_ready = !out_valid | out_ready (combinational); in_fire & out_fire in FULL replaces main.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- Flush: |flush=1 at an edge -> state EMPTY, main and skid = BUBBLE, regardless of in_valid/out_ready. A payload offered with in_fire in the flush cycle is discarded; a downstream out_fire in the flush cycle still completes (downstream owns that handshake). Flush has priority over all transitions; rst has priority over flush.
- Rules: out_data, out_valid stable while out_valid & !out_ready (no payload change under back-pressure). Upstream must hold in_data while in_valid & !in_ready (upstream obligation; bench asserts it).
- occupancy: EMPTY=0, FULL=1, SKID=2.
- Reset mid-operation: any state, any buffered data, discarded in one cycle; no residual valid.

Test Plan:
- Reset then idle: rst=1 one cycle -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, occupancy stays 1, in_ready never drops.
- Back-pressure/skid (SKID=1): send A=0x11, B=0x22 with out_ready=0 -> occupancy 2, in_ready=0, out_data=0x11 held; raise out_ready -> outputs 0x11 then 0x22, in_ready returns to 1 after first out_fire.
- Flush priority: occupancy 2 (A,B), in_valid=1 with C, flush=2'b10 -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE; C never appears.
- Simultaneous in/out in FULL (SKID=0 and SKID=1 builds): main=0x5, in_fire with 0x6 and out_ready=1 -> 0x5 consumed, out_data=0x6, occupancy=1.
- Reset mid-operation: occupancy 2 and flush=0, assert rst -> state EMPTY next cycle; rst and flush both high -> same result, no X on outputs.
